// File: rtl/frontend_fetch_stage.sv
// Instruction fetch front end: one outstanding imem request, single-word
// present buffer toward decode, redirect flush and misaligned-target trap.
//
// Ports:
//   clk, nrst                     clock, async active-low reset
//   stall                         decode not accepting the presented word
//   redirect, redirect_pc         flush-and-refetch pulse with new target
//   imem_req, imem_addr           request valid / word address
//   imem_gnt                      request accepted this cycle
//   imem_rvalid, imem_rdata       response valid / instruction word
//   pc2, instr2                   presented PC and instruction (NOP if none)
//   instruction_addr_misaligned2  presented PC is a misaligned target
module frontend_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc2,
    output logic [31:0] instr2,
    output logic        instruction_addr_misaligned2
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] bpc_q, bpc_d;
    logic [31:0] binstr_q, binstr_d;
    logic        mis_q, mis_d;
    logic        drop_q, drop_d;
    logic        busy;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            vld_q    <= 1'b0;
            bpc_q    <= RESET_PC;
            binstr_q <= NOP_INSTR;
            mis_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            bpc_q    <= bpc_d;
            binstr_q <= binstr_d;
            mis_q    <= mis_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vld_d    = vld_q;
        bpc_d    = bpc_q;
        binstr_d = binstr_q;
        mis_d    = mis_q;
        drop_d   = drop_q;
        // A response is still owed by memory after this edge.
        busy = (state_q == S_WAIT && !imem_rvalid)
            || (state_q == S_FETCH && imem_gnt)
            || (drop_q && !imem_rvalid);
        if (redirect) begin
            pc_d   = redirect_pc;
            drop_d = busy;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d  = S_TRAP;
                vld_d    = 1'b1;
                bpc_d    = redirect_pc;
                binstr_d = NOP_INSTR;
                mis_d    = 1'b1;
            end else begin
                vld_d   = 1'b0;
                mis_d   = 1'b0;
                state_d = busy ? S_WAIT : S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_FETCH;
                        end else begin
                            vld_d    = 1'b1;
                            bpc_d    = pc_q;
                            binstr_d = imem_rdata;
                            mis_d    = 1'b0;
                            pc_d     = pc_q + 32'd4;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        vld_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_TRAP: begin
                    if (vld_q && !stall) vld_d = 1'b0;
                    // Late response to a request abandoned by the trap.
                    if (imem_rvalid) drop_d = 1'b0;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign imem_req  = nrst && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc2       = bpc_q;
    assign instr2    = vld_q ? binstr_q : NOP_INSTR;
    assign instruction_addr_misaligned2 = vld_q && mis_q;

endmodule

// File: tb/tb_frontend_fetch_stage.sv
// Self-checking bench for frontend_fetch_stage: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_frontend_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        mis2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frontend_fetch_stage dut (
        .clk(clk),
        .nrst(nrst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .pc2(pc2),
        .instr2(instr2),
        .instruction_addr_misaligned2(mis2)
    );

    // Memory contents: distinct per word, bit 31 set so never equal to NOP.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {1'b1, a[31:1] ^ 31'h2A5C_3E91};
    endfunction

    task automatic idle();
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        idle();
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
        tick();
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req2 got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        n_cmp++; if (pc2 !== 32'h0) begin n_err++; $display("FAIL rst_pc2 got %h exp 0", pc2); end
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL rst_instr2 got %h exp %h", instr2, NOP); end
        n_cmp++; if (mis2 !== 1'b0) begin n_err++; $display("FAIL rst_mis2 got %b exp 0", mis2); end
        nrst = 1'b1;
        #1;
    endtask

    task automatic test_first_fetch();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ff_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL ff_addr got %h exp 0", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ff_wait_req got %b exp 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (pc2 !== 32'h0) begin n_err++; $display("FAIL ff_pc2 got %h exp 0", pc2); end
        n_cmp++; if (instr2 !== 32'h0050_0093) begin n_err++; $display("FAIL ff_instr2 got %h exp 00500093", instr2); end
        n_cmp++; if (mis2 !== 1'b0) begin n_err++; $display("FAIL ff_mis2 got %b exp 0", mis2); end
        tick();
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL ff_once got %h exp %h", instr2, NOP); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ff_req2 got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL ff_addr2 got %h exp 4", imem_addr); end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = 32'hA1B2_C3D4;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = w;
        tick();
        imem_rvalid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pc2 !== 32'h4) begin n_err++; $display("FAIL st_pc2[%0d] got %h exp 4", i, pc2); end
            n_cmp++; if (instr2 !== w) begin n_err++; $display("FAIL st_instr2[%0d] got %h exp %h", i, instr2, w); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req[%0d] got %b exp 0", i, imem_req); end
            tick();
        end
        stall = 1'b0;
        n_cmp++; if (instr2 !== w) begin n_err++; $display("FAIL st_deliver got %h exp %h", instr2, w); end
        tick();
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL st_once got %h exp %h", instr2, NOP); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL st_next got %h exp 8", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req[%0d] got %b exp 0", i, imem_req); end
            n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL rw_nop[%0d] got %h exp %h", i, instr2, NOP); end
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL rw_drop got %h exp %h", instr2, NOP); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rw_req2 got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rw_addr got %h exp 100", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (pc2 !== 32'h100) begin n_err++; $display("FAIL rw_pc2 got %h exp 100", pc2); end
        n_cmp++; if (instr2 !== 32'h1111_2222) begin n_err++; $display("FAIL rw_instr2 got %h exp 11112222", instr2); end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        tick();
        idle();
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL rr_nop got %h exp %h", instr2, NOP); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rr_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL rr_addr got %h exp 200", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr got %h exp fffffffc", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h3333_4444;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (pc2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_pc2 got %h exp fffffffc", pc2); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wr_next got %h exp 0", imem_addr); end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ma_req[%0d] got %b exp 0", i, imem_req); end
            n_cmp++; if (pc2 !== 32'h102) begin n_err++; $display("FAIL ma_pc2[%0d] got %h exp 102", i, pc2); end
            n_cmp++; if (mis2 !== 1'b1) begin n_err++; $display("FAIL ma_mis2[%0d] got %b exp 1", i, mis2); end
            n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL ma_nop[%0d] got %h exp %h", i, instr2, NOP); end
            if (i == 0) tick();
            stall = 1'b0;
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ma_bub_req[%0d] got %b exp 0", i, imem_req); end
            n_cmp++; if (mis2 !== 1'b0) begin n_err++; $display("FAIL ma_bub_mis[%0d] got %b exp 0", i, mis2); end
            n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL ma_bub_nop[%0d] got %h exp %h", i, instr2, NOP); end
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ma_exit_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h300) begin n_err++; $display("FAIL ma_exit_addr got %h exp 300", imem_addr); end
    endtask

    task automatic test_throughput();
        logic        pg;
        logic [31:0] pa;
        int          cnt;
        pg = 1'b0;
        pa = 32'h0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            imem_rvalid = pg;
            imem_rdata = memf(pa);
            pg = imem_req;
            pa = imem_addr;
            imem_gnt = imem_req;
            if (instr2 !== NOP) cnt++;
            tick();
        end
        idle();
        n_cmp++; if (cnt !== 10) begin n_err++; $display("FAIL tp_count got %0d exp 10", cnt); end
        n_cmp++; if (imem_addr !== 32'h328) begin n_err++; $display("FAIL tp_addr got %h exp 328", imem_addr); end
    endtask

    task automatic test_reset_midflight();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        nrst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mr_req got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL mr_addr got %h exp 0", imem_addr); end
        n_cmp++; if (pc2 !== 32'h0) begin n_err++; $display("FAIL mr_pc2 got %h exp 0", pc2); end
        tick();
        nrst = 1'b1;
        #1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mr_req2 got %b exp 1", imem_req); end
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (instr2 !== NOP) begin n_err++; $display("FAIL mr_stale got %h exp %h", instr2, NOP); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mr_req3 got %b exp 1", imem_req); end
    endtask

    // Reference: memory with one response owed at a time; the delivered
    // stream must be consecutive words from the last redirect target.
    task automatic test_random();
        logic        mem_busy;
        int          mem_lat;
        logic [31:0] mem_addr;
        logic [31:0] exp_fetch;
        logic [31:0] exp_dpc;
        logic        trap_pend;
        logic        trap_mode;
        int          n_deliv;
        mem_busy = 1'b0;
        mem_lat = 0;
        mem_addr = 32'h0;
        exp_fetch = 32'h0;
        exp_dpc = 32'h0;
        trap_pend = 1'b0;
        trap_mode = 1'b0;
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            idle();
            stall = ($urandom % 3) == 0;
            if (($urandom % 25) == 0) begin
                redirect = 1'b1;
                redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if (($urandom % 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            end
            if (mem_busy) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_outstanding c=%0d got req %b exp 0", c, imem_req); end
                mem_lat--;
                if (mem_lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = memf(mem_addr);
                    mem_busy = 1'b0;
                end
            end else if (imem_req === 1'b1) begin
                imem_gnt = $urandom % 2;
                if (imem_gnt) begin
                    mem_busy = 1'b1;
                    mem_lat = $urandom_range(1, 3);
                    mem_addr = imem_addr;
                    if (!redirect) begin
                        n_cmp++; if (imem_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_fetch c=%0d got %h exp %h", c, imem_addr, exp_fetch); end
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
            end
            if (trap_mode) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_trap_req c=%0d got %b exp 0", c, imem_req); end
            end
            if (!redirect && !stall && (instr2 !== NOP || mis2 !== 1'b0)) begin
                n_cmp++; if (pc2 !== exp_dpc) begin n_err++; $display("FAIL rnd_pc2 c=%0d got %h exp %h", c, pc2, exp_dpc); end
                if (trap_pend) begin
                    n_cmp++; if (mis2 !== 1'b1 || instr2 !== NOP) begin n_err++; $display("FAIL rnd_trap c=%0d got mis %b instr %h exp 1 %h", c, mis2, instr2, NOP); end
                    trap_pend = 1'b0;
                end else begin
                    n_cmp++; if (instr2 !== memf(exp_dpc) || mis2 !== 1'b0) begin n_err++; $display("FAIL rnd_instr c=%0d got %h/%b exp %h/0", c, instr2, mis2, memf(exp_dpc)); end
                    exp_dpc = exp_dpc + 32'd4;
                    n_deliv++;
                end
            end
            if (redirect) begin
                exp_fetch = redirect_pc;
                exp_dpc = redirect_pc;
                trap_pend = redirect_pc[1:0] != 2'b00;
                trap_mode = trap_pend;
            end
            tick();
        end
        idle();
        n_cmp++; if (n_deliv < 100) begin n_err++; $display("FAIL rnd_progress got %0d exp >=100", n_deliv); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_misaligned();
        test_throughput();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frontend_fetch_stage.md
FRONTEND_FETCH_STAGE -- requirements
Module: frontend_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble word.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream decode stage not accepting; presented word held.
REQ-006 redirect  input  1  one-cycle pulse, taken branch/jump/trap, flush and refetch.
REQ-007 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  request word address, stable while imem_req=1 and imem_gnt=0.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  response data valid, at least one cycle after grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 pc2  output  32  PC of presented word, to decode.
REQ-014 instr2  output  32  presented instruction, NOP_INSTR when none valid.
REQ-015 instruction_addr_misaligned2  output  1  presented PC misaligned, exception to decode.

Function
REQ-016 FSM states: FETCH, WAIT, HOLD, TRAP; at most one outstanding memory request.
REQ-017 FETCH: imem_req=1, imem_addr=pc_q; on imem_gnt -> WAIT; otherwise stay FETCH.
REQ-018 WAIT: imem_req=0; on imem_rvalid capture {pc_q, imem_rdata} into present buffer (valid=1), pc_q<=pc_q+32'd4 (mod 2^32 wrap), -> HOLD.
REQ-019 HOLD: buffer presented; in any cycle with stall=0 buffer consumed (valid<=0), -> FETCH same cycle edge; stall=1 keeps buffer and state.
REQ-020 Presentation combinational from buffer: valid=1 -> pc2=buf_pc, instr2=buf_instr; valid=0 -> instr2=NOP_INSTR, pc2=last buf_pc, misaligned2=0.
REQ-021 Consumption rule: a valid word is delivered exactly once, in the first cycle it is presented with stall=0.
REQ-022 redirect=1 (any state) overrides all: buffer valid<=0, pc_q<=redirect_pc; higher priority than simultaneous rvalid, gnt, or consumption.
REQ-023 redirect while WAIT or in FETCH cycle with imem_gnt=1: set drop flag; next imem_rvalid discarded, then fetch of redirect_pc begins in FETCH.
REQ-024 While drop flag set, FSM stays WAIT, imem_req=0; drop cleared on the discarded rvalid.
REQ-025 redirect with redirect_pc[1:0]!=2'b00: no memory request; -> TRAP, buffer loaded {redirect_pc, NOP_INSTR} with misaligned flag=1.
REQ-026 TRAP: imem_req=0; flag word presented, consumed per REQ-019; then FSM waits in TRAP (bubbles) until next redirect.
REQ-027 Aligned redirect clears any misaligned flag; misaligned2 only asserted with a valid buffer.
REQ-028 Back-to-back redirects: last one wins; only one drop pending ever (single outstanding request).
REQ-029 Sustained throughput without stall or wait states: one instruction per 3 cycles (FETCH, WAIT, HOLD).
REQ-030 imem_rvalid outside WAIT is ignored; imem_gnt outside FETCH is ignored.

Reset
REQ-031 nrst=0 asynchronously: state=FETCH, pc_q=RESET_PC, buffer valid=0, buf_pc=RESET_PC, drop=0, misaligned flag=0.
REQ-032 During reset outputs: imem_req=0, imem_addr=RESET_PC, pc2=RESET_PC, instr2=NOP_INSTR, misaligned2=0.
REQ-033 First imem_req=1 in first clock cycle after nrst deasserts; reset mid-transaction abandons outstanding request, and stale rvalid after reset is not latched unless in WAIT.

Verification
REQ-034 Reset release, gnt same cycle, rvalid next, rdata=32'h0050_0093 -> imem_addr=0, then pc2=0, instr2=32'h0050_0093 for one cycle, next imem_addr=4.
REQ-035 Word presented with stall=1 for 3 cycles -> pc2/instr2 held constant 3 cycles, imem_req=0, delivered once on stall=0.
REQ-036 redirect to 32'h0000_0100 while WAIT -> next rvalid data discarded, following request imem_addr=32'h100, instr2=NOP_INSTR meanwhile.
REQ-037 redirect to 32'h0000_0102 -> no imem_req, pc2=32'h102, misaligned2=1, instr2=NOP_INSTR, then bubbles until next redirect.
REQ-038 pc_q=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-039 redirect and rvalid same cycle in WAIT -> rvalid data not presented, fetch of redirect_pc follows.
